// File: rtl/stage1_pkg.sv
// stage1_pkg: shared types and encodings for the stage1 multi-cycle core.
//   word_t / tag_t : data word and register tag types
//   stage_t        : sequencer stages
//   op_t           : decoded operation select
//   OPC_* / F3_* / F7_* : supported RV32I opcode and function fields
package stage1_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  tag_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } stage_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_ADDI,
        OP_JAL
    } op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational field extraction and legality check.
//   ir        in   latched instruction word
//   rs1/rs2/rd out register tags
//   imm_i     out  sign-extended I-type immediate
//   imm_j     out  sign-extended J-type (JAL) offset
//   op        out  operation select
//   legal     out  1 when ir is ADD, SUB, ADDI or JAL
module instr_decoder
    import stage1_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm_i,
    output logic [31:0] imm_j,
    output op_t         op,
    output logic        legal
);

    always_comb begin
        rs1   = ir[19:15];
        rs2   = ir[24:20];
        rd    = ir[11:7];
        imm_i = {{20{ir[31]}}, ir[31:20]};
        imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        op    = OP_ADD;
        legal = 1'b0;
        case (ir[6:0])
            OPC_OP: begin
                if (ir[14:12] == F3_ADD && ir[31:25] == F7_ADD) begin
                    op    = OP_ADD;
                    legal = 1'b1;
                end else if (ir[14:12] == F3_ADD && ir[31:25] == F7_SUB) begin
                    op    = OP_SUB;
                    legal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (ir[14:12] == F3_ADD) begin
                    op    = OP_ADDI;
                    legal = 1'b1;
                end
            end
            OPC_JAL: begin
                op    = OP_JAL;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK control
// for one instruction at a time (ADD, SUB, ADDI, JAL).
//   clock, reset        single clock, synchronous active-high reset
//   instruction         instruction memory data, sampled at end of FETCH
//   instruction_addr    current PC, sampled at end of FETCH
//   stall               hold current stage, suppress strobes
//   rs1_read/rs2_read   register file read data
//   rs1/rs2/rd          tags of the latched instruction
//   rd_value            writeback data
//   write_rd            register write enable (never for x0)
//   is_writeback_stage  active WRITEBACK cycle
//   advance_pc / jump   PC update pulses; jump_offset valid with jump
//   illegal             sticky unsupported-instruction flag
//   retired_count       completed instructions (wraps)
module stage_sequencer
    import stage1_pkg::*;
#(
    parameter bit          SKIP_MEMORY = 1'b0,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            instruction,
    input  logic [31:0]            instruction_addr,
    input  logic                   stall,
    input  logic [31:0]            rs1_read,
    input  logic [31:0]            rs2_read,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [31:0]            rd_value,
    output logic                   write_rd,
    output logic                   is_writeback_stage,
    output logic                   advance_pc,
    output logic                   jump,
    output logic [31:0]            jump_offset,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    stage_t      state;
    logic [31:0] ir;
    logic [31:0] pc_q;
    logic [31:0] result_q;
    logic [31:0] imm_i;
    logic [31:0] imm_j;
    op_t         op;
    logic        legal;
    logic        wb_active;

    instr_decoder u_decoder (
        .ir    (ir),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .imm_i (imm_i),
        .imm_j (imm_j),
        .op    (op),
        .legal (legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= FETCH;
            ir            <= '0;
            pc_q          <= '0;
            result_q      <= '0;
            illegal       <= 1'b0;
            retired_count <= '0;
        end else if (!stall) begin
            case (state)
                FETCH: begin
                    ir    <= instruction;
                    pc_q  <= instruction_addr;
                    state <= DECODE;
                end
                DECODE: begin
                    if (legal) begin
                        state <= EXECUTE;
                    end else begin
                        state   <= HALT;
                        illegal <= 1'b1;
                    end
                end
                EXECUTE: begin
                    case (op)
                        OP_ADD:  result_q <= rs1_read + rs2_read;
                        OP_SUB:  result_q <= rs1_read - rs2_read;
                        OP_ADDI: result_q <= rs1_read + imm_i;
                        OP_JAL:  result_q <= pc_q + 32'd4;
                        default: result_q <= '0;
                    endcase
                    state <= SKIP_MEMORY ? WRITEBACK : MEMORY;
                end
                MEMORY: state <= WRITEBACK;
                WRITEBACK: begin
                    retired_count <= retired_count + COUNT_WIDTH'(1);
                    state         <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    // Strobes depend on the same-cycle stall so a stalled WRITEBACK commits
    // only in its first unstalled cycle; data outputs come from registers.
    assign wb_active = (state == WRITEBACK) && !stall;

    always_comb begin
        rd_value           = result_q;
        is_writeback_stage = wb_active;
        write_rd           = wb_active && (rd != 5'd0);
        jump               = wb_active && (op == OP_JAL);
        advance_pc         = wb_active && (op != OP_JAL);
        jump_offset        = (wb_active && op == OP_JAL) ? imm_j : '0;
    end

endmodule
